hex_tx_fmt: RTL
===============

HEX_TX_FMT -- requirements
Module: hex_tx_fmt

Interface
REQ-001 Parameter NIBBLES, default 8: hex digits per word; legal range 1..16.
REQ-002 Parameter CRLF_EN, default 1: 1 = append CR (0x0D), LF (0x0A) after each hex-mode word.
REQ-003 Parameter LZS_EN, default 0: 1 = suppress leading zero digits in hex mode.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  word present on in_data/in_mode.
REQ-008 in_ready  out  1  block can accept a word.
REQ-009 in_data  in  4*NIBBLES  word to format.
REQ-010 in_mode  in  1  0 = raw byte (in_data[7:0]); 1 = hex text.
REQ-011 out_valid  out  1  out_byte holds a valid character.
REQ-012 out_ready  in  1  downstream (UART TX) takes out_byte.
REQ-013 out_byte  out  8  character to transmit.
REQ-014 busy  out  1  frame in progress (not IDLE).

Function
REQ-015 FSM states: IDLE, HEX, CR, LF, RAW; the only state that accepts input is IDLE.
REQ-016 in_ready SHALL equal (state==IDLE); busy SHALL equal its inverse.
REQ-017 Accept = in_valid & in_ready; on accept, capture in_data into a shift register, in_mode, and the starting digit index; in_valid while busy SHALL be ignored with no effect.
REQ-018 Latency: out_valid SHALL rise in the cycle after accept, carrying the first character.
REQ-019 Transfer = out_valid & out_ready; out_byte and out_valid SHALL hold stable while out_valid & !out_ready.
REQ-020 Exactly one character SHALL advance per transfer; no characters are skipped or repeated.
REQ-021 Hex digit map: 0-9 -> 0x30-0x39; A-F -> 0x41-0x46 (uppercase only).
REQ-022 HEX state: emit digits MSB-first, from digit NIBBLES-1 down to digit 0; digit index counter width = clog2(NIBBLES+1).
REQ-023 LZS_EN=1: the first digit emitted is the most significant non-zero digit; an all-zero word emits a single 0x30.
REQ-024 After the last digit: if CRLF_EN=1, go HEX->CR->LF->IDLE; otherwise go HEX->IDLE.
REQ-025 RAW state with captured byte 0xFF: emit 0x0D, then 0x0A (via CR, LF), then IDLE.
REQ-026 RAW state with any other byte: emit the byte once, then IDLE; CRLF_EN does not apply.
REQ-027 On the transfer of the last character, the next state is IDLE, out_valid is 0 and in_ready is 1 in the following cycle (one bubble between frames).
REQ-028 out_byte SHALL be 0x00 whenever out_valid is 0.

Reset
REQ-029 rst=1 SHALL force immediately (asynchronous): state IDLE, out_valid 0, out_byte 0x00, in_ready 1, busy 0, shift register and counter cleared.
REQ-030 Reset mid-frame SHALL abandon the frame with no further characters; the first accept after release starts a fresh frame.

Verification
REQ-031 NIBBLES=8, CRLF_EN=1, hex 0x1234ABCD, out_ready=1 -> 31 32 33 34 41 42 43 44 0D 0A on 10 consecutive cycles; in_ready low 10 cycles, high on the 11th.
REQ-032 Raw 0xFF -> 0D 0A, then idle; raw 0x41 -> single 41.
REQ-033 Hex 0x1234ABCD with out_ready low 3 cycles while 0x32 is presented -> 0x32 and out_valid held for 3 cycles; remaining sequence intact.
REQ-034 LZS_EN=1: 0x0000000F -> 46 0D 0A; 0x00000000 -> 30 0D 0A; 0x10000000 -> 31 30 30 30 30 30 30 30 0D 0A.
REQ-035 rst pulsed after the 3rd transfer of a hex frame -> out_valid 0 asynchronously, no further bytes; the next word (raw 0x41) -> 41 only.
REQ-036 in_valid held high with a different word throughout a frame -> that word is not captured until the cycle in_ready returns to 1; then it is accepted exactly once.

Source files
------------

// File: rtl/hex_tx_fmt.sv
// hex_tx_fmt: turns one accepted word into a short character stream for a
// UART transmitter. Hex mode prints the word as uppercase ASCII hex digits
// (optionally without leading zeros, optionally followed by CR LF). Raw mode
// passes the low byte through, except that 0xFF is sent as CR LF.
module hex_tx_fmt #(
   parameter int NIBBLES = 8,    // hex digits per word, 1..16
   parameter bit CRLF_EN = 1'b1, // append CR LF after each hex word
   parameter bit LZS_EN  = 1'b0  // suppress leading zero digits in hex mode
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   in_data,
   input  logic                   in_mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [7:0]             out_byte,
   output logic                   busy
);

   localparam int DW = 4 * NIBBLES;
   // The shift register must also hold a raw byte when the word is narrower.
   localparam int SW = (DW < 8) ? 8 : DW;
   localparam int CW = $clog2(NIBBLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEX,
      S_CR,
      S_LF,
      S_RAW
   } state_e;

   state_e          state_q, state_d;
   logic [SW-1:0]   shift_q, shift_d;
   logic [CW-1:0]   cnt_q, cnt_d;     // digits still to be emitted, current one included

   logic [CW-1:0]   msd_idx;
   logic [CW-1:0]   lead_zeros;
   logic [DW-1:0]   aligned;
   logic [CW-1:0]   first_cnt;
   logic [SW-1:0]   raw_in;
   logic [3:0]      cur_digit;
   logic [7:0]      hex_char;

   // Locate the most significant non-zero digit of the incoming word (0 if all zero).
   always_comb begin
      msd_idx = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (in_data[4*i +: 4] != 4'h0) msd_idx = CW'(i);
      end
   end

   // With suppression on, the word is pre-shifted so its first printed digit
   // sits in the top nibble; the digit counter then starts below NIBBLES.
   assign lead_zeros = CW'(NIBBLES - 1) - msd_idx;
   assign aligned    = LZS_EN ? (in_data << {lead_zeros, 2'b00}) : in_data;
   assign first_cnt  = LZS_EN ? (msd_idx + CW'(1)) : CW'(NIBBLES);
   assign raw_in     = SW'(in_data);

   assign cur_digit  = shift_q[DW-1 -: 4];
   assign hex_char   = (cur_digit < 4'd10) ? (8'h30 + {4'h0, cur_digit})
                                           : (8'h37 + {4'h0, cur_digit});

   assign in_ready   = (state_q == S_IDLE);
   assign busy       = ~in_ready;

   // Next-state, datapath update and character output of the formatter FSM.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a variable unassigned and infer a latch.
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      out_valid = (state_q != S_IDLE);
      out_byte  = 8'h00;

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (in_mode) begin
                  shift_d = SW'(aligned);
                  cnt_d   = first_cnt;
                  state_d = S_HEX;
               end else begin
                  shift_d = raw_in;
                  cnt_d   = '0;
                  state_d = (raw_in[7:0] == 8'hFF) ? S_CR : S_RAW;
               end
            end
         end
         S_HEX: begin
            out_byte = hex_char;
            if (out_ready) begin
               shift_d = shift_q << 4;
               cnt_d   = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_d = CRLF_EN ? S_CR : S_IDLE;
            end
         end
         S_CR: begin
            out_byte = 8'h0D;
            if (out_ready) state_d = S_LF;
         end
         S_LF: begin
            out_byte = 8'h0A;
            if (out_ready) state_d = S_IDLE;
         end
         S_RAW: begin
            out_byte = shift_q[7:0];
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, shift register and digit counter; reset abandons any frame at once.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the shift register is cleared on reset like the rest of the state,
      // so a stale word can never leak into the first frame after reset.
      if (rst) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
